// File: rtl/sysbus_arb_pkg.sv
// Shared types for the Sysbus line arbiter: request tag layout, tag constants,
// client privilege encoding and the transfer state machine encoding.
package sysbus_arb_pkg;

    typedef struct packed {
        logic       wr;
        logic [3:0] t;
        logic [7:0] priv;
    } sysbus_tag_t;

    localparam logic       READ   = 1'b0;
    localparam logic       WRITE  = 1'b1;
    localparam logic [3:0] MEMORY = 4'h1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WR_BEAT,
        RD_WAIT,
        DONE
    } arb_state_t;

    // Each client owns one priv bit, starting at bit 1, so that response
    // beats can be steered back to the client that issued the request.
    function automatic logic [7:0] priv_enc(input logic [2:0] idx);
        return 8'h02 << idx;
    endfunction

endpackage

// File: rtl/sysbus_line_arbiter_arb_pick.sv
// Combinational winner selection for the line arbiter: fixed priority by
// default, round-robin from the last grant when ARB_ROUND_ROBIN_EN is defined.
module arb_pick
    import sysbus_arb_pkg::*;
#(
    parameter int N_CLIENTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [N_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [N_CLIENTS-1:0] grant,
    output logic                 valid
);

    assign valid = |req;

`ifdef ARB_ROUND_ROBIN_EN
    // Search starts one past the last winner and wraps, so a client that was
    // just served drops to the back of the queue.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= N_CLIENTS; i++) begin
            if (!found && req[(int'(rr_ptr) + i) % N_CLIENTS]) begin
                grant[(int'(rr_ptr) + i) % N_CLIENTS] = 1'b1;
                found = 1'b1;
            end
        end
    end
`else
    logic ptr_unused;
    assign ptr_unused = ^rr_ptr;

    // Scanning downwards lets the lowest requesting index overwrite the rest.
    always_comb begin
        grant = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sysbus_line_arbiter.sv
// Line-granular arbiter between N cache clients and the Sysbus master port.
// Optional round-robin arbitration is selected with the ARB_ROUND_ROBIN_EN macro.
module sysbus_line_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int N_CLIENTS = 2,
    parameter int BUS_W     = 64,
    parameter int LINE_W    = 512,
    parameter int TAG_W     = 13
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CLIENTS-1:0]        cl_req,
    input  logic [N_CLIENTS-1:0]        cl_wr,
    input  logic [N_CLIENTS*64-1:0]     cl_addr,
    input  logic [N_CLIENTS*LINE_W-1:0] cl_wdata,
    output logic [N_CLIENTS-1:0]        cl_reqack,
    output logic [N_CLIENTS-1:0]        cl_done,
    output logic [LINE_W-1:0]           cl_rdata,
    output logic                        bus_reqcyc,
    output logic [BUS_W-1:0]            bus_req,
    output logic [TAG_W-1:0]            bus_reqtag,
    input  logic                        bus_reqack,
    input  logic                        bus_respcyc,
    input  logic [BUS_W-1:0]            bus_resp,
    input  logic [TAG_W-1:0]            bus_resptag,
    output logic                        bus_respack
);

    localparam int BEATS = LINE_W / BUS_W;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      g_q;
    logic                  wr_q;
    sysbus_tag_t           tag_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [LINE_W-1:0]     rdata_q;
    logic [IDX_W-1:0]      rr_q;

    logic [N_CLIENTS-1:0]  pick_grant;
    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;

    sysbus_tag_t           resp_tag;
    logic                  resp_tag_unused;
    logic                  beat_hit;
    logic                  grant_now;

    logic [63:0]           sel_addr;
    logic [LINE_W-1:0]     sel_line;
    logic [BUS_W-1:0]      sel_beat;

    arb_pick #(
        .N_CLIENTS (N_CLIENTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req    (cl_req),
        .rr_ptr (rr_q),
        .grant  (pick_grant),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (pick_grant[i]) pick_idx = IDX_W'(i);
        end
    end

    assign grant_now = (state_q == IDLE) && pick_valid;

    // Only the priv field routes a response; wr and type are not checked.
    assign resp_tag        = bus_resptag;
    assign resp_tag_unused = ^{resp_tag.wr, resp_tag.t};
    assign beat_hit        = (state_q == RD_WAIT) && bus_respcyc && (resp_tag.priv == tag_q.priv);
    assign bus_respack     = bus_respcyc;

    assign sel_addr = cl_addr[int'(g_q)*64 +: 64];
    assign sel_line = cl_wdata[int'(g_q)*LINE_W +: LINE_W];
    assign sel_beat = sel_line[int'(cnt_q)*BUS_W +: BUS_W];

    always_comb begin
        line_d = line_q;
        line_d[int'(cnt_q)*BUS_W +: BUS_W] = bus_resp;
    end

    assign cl_rdata = rdata_q;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        cl_reqack  = '0;
        cl_done    = '0;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        case (state_q)
            IDLE: begin
                // Gating with reset keeps every output at 0 while reset is held.
                if (pick_valid && !reset) begin
                    cl_reqack = pick_grant;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = BUS_W'(sel_addr);
                bus_reqtag = tag_q;
                if (bus_reqack) state_d = wr_q ? WR_BEAT : RD_WAIT;
            end
            WR_BEAT: begin
                bus_reqcyc = 1'b1;
                bus_req    = sel_beat;
                bus_reqtag = tag_q;
                if (cnt_q == LAST_BEAT) state_d = DONE;
            end
            RD_WAIT: begin
                if (beat_hit && (cnt_q == LAST_BEAT)) state_d = DONE;
            end
            DONE: begin
                cl_done = N_CLIENTS'(1) << g_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            g_q     <= '0;
            wr_q    <= READ;
            tag_q   <= '0;
            cnt_q   <= '0;
            // NOTE: the line buffers are reset deliberately, so cl_rdata reads 0 until the first read completes.
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
            state_q <= state_d;
            if (grant_now) begin
                g_q   <= pick_idx;
                wr_q  <= cl_wr[pick_idx];
                tag_q <= '{wr: cl_wr[pick_idx], t: MEMORY, priv: priv_enc(3'(pick_idx))};
                cnt_q <= '0;
            end
            if ((state_q == WR_BEAT) || beat_hit) cnt_q <= cnt_q + 1'b1;
            if (beat_hit) begin
                line_q <= line_d;
                if (cnt_q == LAST_BEAT) rdata_q <= line_d;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          rr_q <= '0;
        else if (grant_now) rr_q <= pick_idx;
    end
`else
    assign rr_q = '0;
`endif

endmodule
